cdb_arbiter: RTL and testbench

Result-broadcast arbiter between the functional units and the ROB. It accepts completed results from NUM_REQ functional units (ALU = requester 0, LS = requester 1) through valid/ready handshakes and buffers each unit's results in a private FIFO. Each cycle it grants the single common data bus to one requester, round-robin. The registered bus output feeds the ROB's broadcast inputs, which the ROB forwards to the reservation stations.

---
 rtl/cdb_arbiter_if.sv | 40 ++++
 rtl/cdb_arbiter.sv | 145 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Bundles the functional-unit result handshakes and the registered common
// data bus driven by cdb_arbiter toward the ROB.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif

interface cdb_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                     in_fu_valid;
  logic [NUM_REQ-1:0][`GPR_SIZE-1:0]      in_fu_value;
  logic [NUM_REQ-1:0][`ROB_IDX_SIZE-1:0]  in_fu_dst_rob_index;
  logic [NUM_REQ-1:0]                     in_fu_set_nzcv;
  logic [NUM_REQ-1:0][3:0]                in_fu_nzcv;
  logic [NUM_REQ-1:0]                     out_fu_ready;

  logic                                   out_cdb_done;
  logic [`ROB_IDX_SIZE-1:0]               out_cdb_index;
  logic [`GPR_SIZE-1:0]                   out_cdb_value;
  logic                                   out_cdb_set_nzcv;
  logic [3:0]                             out_cdb_nzcv;
  logic [SRC_W-1:0]                       out_cdb_src;

  modport master (
    output in_fu_valid, in_fu_value, in_fu_dst_rob_index, in_fu_set_nzcv, in_fu_nzcv,
    input  out_fu_ready, out_cdb_done, out_cdb_index, out_cdb_value,
           out_cdb_set_nzcv, out_cdb_nzcv, out_cdb_src
  );

  modport slave (
    input  in_fu_valid, in_fu_value, in_fu_dst_rob_index, in_fu_set_nzcv, in_fu_nzcv,
    output out_fu_ready, out_cdb_done, out_cdb_index, out_cdb_value,
           out_cdb_set_nzcv, out_cdb_nzcv, out_cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Buffers results from each functional unit in a private FIFO and grants the
// single registered common data bus to one non-empty FIFO per cycle, round-robin.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif

module cdb_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic          in_clk,
  input  logic          in_rst_n,
  input  logic          in_flush,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [`GPR_SIZE-1:0]     value;
    logic [`ROB_IDX_SIZE-1:0] rob_idx;
    logic                     set_nzcv;
    logic [3:0]               nzcv;
  } entry_t;

  entry_t           mem_q   [NUM_REQ][QUEUE_DEPTH];
  logic [PTR_W-1:0] head_q  [NUM_REQ];
  logic [PTR_W-1:0] head_d  [NUM_REQ];
  logic [PTR_W-1:0] tail_q  [NUM_REQ];
  logic [PTR_W-1:0] tail_d  [NUM_REQ];
  logic [CNT_W-1:0] count_q [NUM_REQ];
  logic [CNT_W-1:0] count_d [NUM_REQ];
  logic [SRC_W-1:0] last_grant_q, last_grant_d;
  logic             cdb_done_q, cdb_done_d;
  entry_t           cdb_q, cdb_d;
  logic [SRC_W-1:0] cdb_src_q, cdb_src_d;

  entry_t           in_entry [NUM_REQ];
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic             grant_valid;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] cand;
  entry_t           grant_entry;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      ready[i]             = (count_q[i] != CNT_W'(QUEUE_DEPTH));
      in_entry[i].value    = bus.in_fu_value[i];
      in_entry[i].rob_idx  = bus.in_fu_dst_rob_index[i];
      in_entry[i].set_nzcv = bus.in_fu_set_nzcv[i];
      in_entry[i].nzcv     = bus.in_fu_nzcv[i];
    end
  end

  // Scan downward so the candidate closest after last_grant is assigned last and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = SRC_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (count_q[cand] != '0) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_entry = mem_q[grant_idx][head_q[grant_idx]];

  always_comb begin
    push         = '0;
    pop          = '0;
    last_grant_d = last_grant_q;
    cdb_done_d   = 1'b0;
    cdb_d        = cdb_q;
    cdb_src_d    = cdb_src_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      push[i] = bus.in_fu_valid[i] & ready[i] & ~in_flush;
      pop[i]  = grant_valid & (grant_idx == SRC_W'(i)) & ~in_flush;
      if (in_flush) begin
        head_d[i]  = '0;
        tail_d[i]  = '0;
        count_d[i] = '0;
      end else begin
        head_d[i]  = head_q[i] + PTR_W'(pop[i]);
        tail_d[i]  = tail_q[i] + PTR_W'(push[i]);
        count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
    if (grant_valid && !in_flush) begin
      cdb_done_d   = 1'b1;
      cdb_d        = grant_entry;
      cdb_src_d    = grant_idx;
      last_grant_d = grant_idx;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the counts.
  always_ff @(posedge in_clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        mem_q[i][tail_q[i]] <= in_entry[i];
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      last_grant_q <= SRC_W'(NUM_REQ - 1);
      cdb_done_q   <= 1'b0;
      cdb_q        <= '0;
      cdb_src_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        count_q[i] <= count_d[i];
      end
      last_grant_q <= last_grant_d;
      cdb_done_q   <= cdb_done_d;
      cdb_q        <= cdb_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign bus.out_fu_ready     = ready;
  assign bus.out_cdb_done     = cdb_done_q;
  assign bus.out_cdb_index    = cdb_q.rob_idx;
  assign bus.out_cdb_value    = cdb_q.value;
  assign bus.out_cdb_set_nzcv = cdb_q.set_nzcv;
  assign bus.out_cdb_nzcv     = cdb_q.nzcv;
  assign bus.out_cdb_src      = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter: a queue-based reference model
// predicts each broadcast, and a negedge monitor checks the bus against it.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif

module tb_cdb_arbiter;
  localparam int NUM_REQ     = 2;
  localparam int QUEUE_DEPTH = 2;
  localparam int GW          = `GPR_SIZE;
  localparam int RW          = `ROB_IDX_SIZE;

  logic clk = 1'b0;
  logic rstN;
  logic flush;

  cdb_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .QUEUE_DEPTH(QUEUE_DEPTH)) dut (
    .in_clk   (clk),
    .in_rst_n (rstN),
    .in_flush (flush),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [GW-1:0] value;
    logic [RW-1:0] idx;
    logic          setN;
    logic [3:0]    nzcv;
  } res_t;

  typedef struct {
    int   cycle;
    int   src;
    res_t r;
  } exp_t;

  res_t fuQ [NUM_REQ][$];
  exp_t expQ[$];
  int   cycleNum    = 0;
  int   lastGrant   = NUM_REQ - 1;
  bit   modelLive   = 1'b0;
  bit   expReset    = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic checkOutput(input string name, input bit ok, input string detail);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: %s", name, cycleNum, detail);
    end
  endtask

  // Reference model: arbitrate on the queue contents seen before the edge,
  // then accept new results into queues that were not full before the edge.
  always @(posedge clk) begin : model
    int   sz [NUM_REQ];
    int   c;
    exp_t e;
    res_t r;
    cycleNum++;
    if (!rstN) begin
      for (int i = 0; i < NUM_REQ; i++) fuQ[i].delete();
      lastGrant = NUM_REQ - 1;
      modelLive = 1'b1;
      expReset  = 1'b1;
    end else if (flush) begin
      for (int i = 0; i < NUM_REQ; i++) fuQ[i].delete();
    end else begin
      for (int i = 0; i < NUM_REQ; i++) sz[i] = fuQ[i].size();
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (lastGrant + k) % NUM_REQ;
        if (sz[c] > 0) begin
          e.cycle   = cycleNum;
          e.src     = c;
          e.r       = fuQ[c].pop_front();
          expQ.push_back(e);
          lastGrant = c;
          break;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.in_fu_valid[i] && sz[i] < QUEUE_DEPTH) begin
          r.value = bus.in_fu_value[i];
          r.idx   = bus.in_fu_dst_rob_index[i];
          r.setN  = bus.in_fu_set_nzcv[i];
          r.nzcv  = bus.in_fu_nzcv[i];
          fuQ[i].push_back(r);
        end
      end
    end
  end

  // Monitor: pops an expectation whenever the bus shows a broadcast.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   expRdy;
    if (modelLive) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        expRdy = (fuQ[i].size() != QUEUE_DEPTH);
        checkOutput($sformatf("ready%0d", i), bus.out_fu_ready[i] === expRdy,
                    $sformatf("got %b want %b", bus.out_fu_ready[i], expRdy));
      end
      if (bus.out_cdb_done === 1'b1) begin
        if (expQ.size() == 0 || expQ[0].cycle != cycleNum) begin
          checkOutput("unexpected_bcast", 1'b0,
                      $sformatf("got done=1 idx=%0d src=%0d want done=0",
                                bus.out_cdb_index, bus.out_cdb_src));
        end else begin
          e = expQ.pop_front();
          checkOutput("bcast",
                      bus.out_cdb_index === e.r.idx && bus.out_cdb_value === e.r.value &&
                      bus.out_cdb_set_nzcv === e.r.setN && bus.out_cdb_nzcv === e.r.nzcv &&
                      int'(bus.out_cdb_src) == e.src,
                      $sformatf("got idx=%0d val=%0h set=%b nzcv=%b src=%0d want idx=%0d val=%0h set=%b nzcv=%b src=%0d",
                                bus.out_cdb_index, bus.out_cdb_value, bus.out_cdb_set_nzcv,
                                bus.out_cdb_nzcv, bus.out_cdb_src,
                                e.r.idx, e.r.value, e.r.setN, e.r.nzcv, e.src));
        end
      end else if (bus.out_cdb_done === 1'b0) begin
        if (expQ.size() > 0 && expQ[0].cycle <= cycleNum) begin
          e = expQ.pop_front();
          checkOutput("missing_bcast", 1'b0,
                      $sformatf("got done=0 want done=1 idx=%0d src=%0d", e.r.idx, e.src));
        end else begin
          checkOutput("idle", 1'b1, "");
        end
        if (expReset) begin
          checkOutput("reset_outputs",
                      bus.out_cdb_index === '0 && bus.out_cdb_value === '0 &&
                      bus.out_cdb_set_nzcv === 1'b0 && bus.out_cdb_nzcv === 4'b0 &&
                      bus.out_cdb_src === '0,
                      $sformatf("got idx=%0d val=%0h set=%b nzcv=%b src=%0d want all zero",
                                bus.out_cdb_index, bus.out_cdb_value, bus.out_cdb_set_nzcv,
                                bus.out_cdb_nzcv, bus.out_cdb_src));
        end
      end else begin
        checkOutput("done_known", 1'b0, $sformatf("got done=%b want 0 or 1", bus.out_cdb_done));
      end
      expReset = 1'b0;
    end
  end

  task automatic applyStimulus(input logic r, input logic f, input logic [1:0] v,
                               input logic [RW-1:0] idx0, input logic [RW-1:0] idx1,
                               input logic [GW-1:0] val0, input logic [GW-1:0] val1,
                               input logic [1:0] setN, input logic [3:0] nz0,
                               input logic [3:0] nz1);
    rstN                       = r;
    flush                      = f;
    bus.in_fu_valid            = v;
    bus.in_fu_dst_rob_index[0] = idx0;
    bus.in_fu_dst_rob_index[1] = idx1;
    bus.in_fu_value[0]         = val0;
    bus.in_fu_value[1]         = val1;
    bus.in_fu_set_nzcv         = setN;
    bus.in_fu_nzcv[0]          = nz0;
    bus.in_fu_nzcv[1]          = nz1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 2'b00, '0, '0, '0, '0, 2'b00, 4'h0, 4'h0);
  endtask

  task automatic randomStim(input logic r, input logic f, input logic [1:0] v);
    applyStimulus(r, f, v, RW'($urandom), RW'($urandom),
                  {GW'($urandom), 32'($urandom)}, {GW'($urandom), 32'($urandom)},
                  2'($urandom), 4'($urandom), 4'($urandom));
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, '0, '0, 2'b00, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, '0, '0, 2'b00, 4'h0, 4'h0);
    idle(1);

    applyStimulus(1'b1, 1'b0, 2'b01, 6'd5, '0, 64'd42, '0, 2'b00, 4'h0, 4'h0);
    idle(3);

    applyStimulus(1'b1, 1'b0, 2'b11, 6'd3, 6'd7, 64'd300, 64'd700, 2'b00, 4'h0, 4'h0);
    idle(3);
    applyStimulus(1'b1, 1'b0, 2'b01, 6'd1, '0, 64'd11, '0, 2'b00, 4'h0, 4'h0);
    idle(2);
    applyStimulus(1'b1, 1'b0, 2'b11, 6'd9, 6'd10, 64'd900, 64'd1000, 2'b00, 4'h0, 4'h0);
    idle(3);

    for (int i = 0; i < 8; i++) randomStim(1'b1, 1'b0, 2'b11);
    idle(5);

    applyStimulus(1'b1, 1'b0, 2'b11, 6'd20, 6'd21, 64'd1, 64'd2, 2'b10, 4'b1111, 4'b0110);
    idle(3);

    for (int i = 0; i < 4; i++) randomStim(1'b1, 1'b0, 2'b11);
    randomStim(1'b1, 1'b1, 2'b11);
    idle(3);

    for (int i = 0; i < 4; i++) randomStim(1'b1, 1'b0, 2'b11);
    randomStim(1'b0, 1'b1, 2'b11);
    randomStim(1'b1, 1'b0, 2'b11);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      randomStim(($urandom_range(63) != 0), ($urandom_range(31) == 0),
                 {($urandom_range(9) < 7), ($urandom_range(9) < 7)});
    end
    idle(6);

    checkOutput("drained", expQ.size() == 0,
                $sformatf("got %0d pending broadcasts want 0", expQ.size()));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
